// File: rtl/alu_mdu_ctrl_if.sv
// ALU request bus: the mul/div controller drives operands and run, the ALU answers with ack and Y.
`ifndef ALUOP_L
`define ALUOP_L 4
`endif

interface alu_mdu_ctrl_if #(
  parameter int OPR_L = 32
);
  logic [OPR_L-1:0]    alu_A;
  logic [OPR_L-1:0]    alu_B;
  logic                alu_c;
  logic [`ALUOP_L-1:0] alu_op;
  logic                alu_run;
  logic                alu_ack;
  logic [OPR_L-1:0]    alu_Y;

  modport master (
    output alu_A, alu_B, alu_c, alu_op, alu_run,
    input  alu_ack, alu_Y
  );

  modport slave (
    input  alu_A, alu_B, alu_c, alu_op, alu_run,
    output alu_ack, alu_Y
  );
endinterface

// File: rtl/alu_mdu_ctrl.sv
// Iterative unsigned multiply/divide sequencer borrowing an external ALU over a four-phase run/ack handshake.
// Optional macro ALU_MDU_DIV_EN builds the restoring divider; without it divide requests finish with err=1.
`ifndef ALUOP_L
`define ALUOP_L 4
`endif

module alu_mdu_ctrl #(
  parameter int OPR_L = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_div,
  input  logic [OPR_L-1:0] opa,
  input  logic [OPR_L-1:0] opb,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [OPR_L-1:0] hi,
  output logic [OPR_L-1:0] lo,
  alu_mdu_ctrl_if.master   alu
);

  // Opcode encodings shared with the ALU (alu_opcode.v).
  localparam logic [`ALUOP_L-1:0] ALU_ADD  = `ALUOP_L'(0);
  localparam logic [`ALUOP_L-1:0] ALU_SUB  = `ALUOP_L'(1);
  localparam logic [`ALUOP_L-1:0] ALU_SLTU = `ALUOP_L'(3);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, WAIT_REL, STEP, FIN} state_t;
  typedef enum logic [1:0] {PH_DECIDE, PH_FIRST, PH_SECOND} phase_t;

  state_t              state, state_nxt;
  phase_t              phase;
  logic [5:0]          cnt;
  logic [OPR_L-1:0]    md;
  logic [OPR_L-1:0]    sum;
  logic [OPR_L-1:0]    y_r;
  logic [OPR_L-1:0]    hi_r, lo_r;
  logic                err_r;
  logic                run_r;
  logic [OPR_L-1:0]    a_r, b_r;
  logic [`ALUOP_L-1:0] op_r;
`ifdef ALU_MDU_DIV_EN
  logic                div_q;
`endif

  logic                reject;
  logic                need_alu;
  logic                last_iter;
  logic [OPR_L-1:0]    nxt_a;
  logic [`ALUOP_L-1:0] nxt_op;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // need_alu is evaluated in STEP: does the current iteration still owe an ALU request?
  always_comb begin
    state_nxt = state;
`ifdef ALU_MDU_DIV_EN
    reject    = op_div && (opb == '0);
`else
    reject    = op_div;
`endif
    need_alu  = ((phase == PH_DECIDE) && lo_r[0]) || (phase == PH_FIRST);
    nxt_a     = (phase == PH_SECOND) ? sum : hi_r;
    nxt_op    = (phase == PH_SECOND) ? ALU_SLTU : ALU_ADD;
`ifdef ALU_MDU_DIV_EN
    if (div_q) begin
      need_alu = (phase == PH_DECIDE) || ((phase == PH_FIRST) && !y_r[0]);
      nxt_a    = hi_r;
      nxt_op   = (phase == PH_FIRST) ? ALU_SLTU : ALU_SUB;
    end
`endif
    last_iter = !need_alu && (cnt == 6'd31);

    case (state)
      IDLE:     if (start) state_nxt = reject ? FIN : STEP;
      ISSUE:    if (!alu.alu_ack) state_nxt = WAIT_ACK;
      WAIT_ACK: if (alu.alu_ack) state_nxt = WAIT_REL;
      WAIT_REL: if (!alu.alu_ack) state_nxt = STEP;
      STEP:     state_nxt = need_alu ? ISSUE : (last_iter ? FIN : STEP);
      FIN:      state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Operand registers only load on the cycle run rises, so they stay frozen across run/ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= PH_DECIDE;
      cnt   <= 6'd0;
      md    <= '0;
      sum   <= '0;
      y_r   <= '0;
      hi_r  <= '0;
      lo_r  <= '0;
      err_r <= 1'b0;
      run_r <= 1'b0;
      a_r   <= '0;
      b_r   <= '0;
      op_r  <= '0;
`ifdef ALU_MDU_DIV_EN
      div_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          md    <= opb;
          cnt   <= 6'd0;
          phase <= PH_DECIDE;
          hi_r  <= '0;
          lo_r  <= opa;
          err_r <= 1'b0;
`ifdef ALU_MDU_DIV_EN
          div_q <= op_div;
          if (reject) begin
            hi_r  <= opa;
            lo_r  <= '1;
            err_r <= 1'b1;
          end
`else
          if (reject) begin
            lo_r  <= '0;
            err_r <= 1'b1;
          end
`endif
        end
        ISSUE: if (!alu.alu_ack) begin
          run_r <= 1'b1;
          a_r   <= nxt_a;
          b_r   <= md;
          op_r  <= nxt_op;
        end
        WAIT_ACK: if (alu.alu_ack) begin
          y_r   <= alu.alu_Y;
          run_r <= 1'b0;
        end
        STEP: begin
`ifdef ALU_MDU_DIV_EN
          if (div_q) begin
            // A set r32 after the shift already guarantees rem >= divisor, so the compare is skipped.
            case (phase)
              PH_DECIDE: begin
                {hi_r, lo_r} <= {hi_r[OPR_L-2:0], lo_r, 1'b0};
                phase        <= hi_r[OPR_L-1] ? PH_SECOND : PH_FIRST;
              end
              PH_FIRST: if (!y_r[0]) phase <= PH_SECOND;
              default: begin
                hi_r    <= y_r;
                lo_r[0] <= 1'b1;
              end
            endcase
          end else
`endif
          begin
            case (phase)
              PH_DECIDE: begin
                if (lo_r[0]) phase <= PH_FIRST;
                else         {hi_r, lo_r} <= {1'b0, hi_r, lo_r[OPR_L-1:1]};
              end
              PH_FIRST: begin
                sum   <= y_r;
                phase <= PH_SECOND;
              end
              default: {hi_r, lo_r} <= {y_r[0], sum, lo_r[OPR_L-1:1]};
            endcase
          end
          if (!need_alu) begin
            phase <= PH_DECIDE;
            cnt   <= last_iter ? 6'd0 : cnt + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (state != IDLE);
  assign done        = (state == FIN);
  assign err         = err_r;
  assign hi          = hi_r;
  assign lo          = lo_r;
  assign alu.alu_A   = a_r;
  assign alu.alu_B   = b_r;
  assign alu.alu_op  = op_r;
  assign alu.alu_run = run_r;
  assign alu.alu_c   = 1'b0;

endmodule

// File: tb/tb_alu_mdu_ctrl.sv
// Self-checking bench for alu_mdu_ctrl: vector table plus scoreboard, random-latency ALU model,
// operand-stability monitor and hand-written reset / start-overlap sequences.
`ifndef ALUOP_L
`define ALUOP_L 4
`endif

module tb_alu_mdu_ctrl;
  localparam int W = 32;
  localparam logic [`ALUOP_L-1:0] OP_ADD  = `ALUOP_L'(0);
  localparam logic [`ALUOP_L-1:0] OP_SUB  = `ALUOP_L'(1);
  localparam logic [`ALUOP_L-1:0] OP_SLTU = `ALUOP_L'(3);

  typedef struct {
    int         id;
    logic       op_div;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
    logic       exp_err;
    int         exp_runs;
    int         exp_lat;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         op_div;
  logic [W-1:0] opa, opb;
  logic         busy, done, err;
  logic [W-1:0] hi, lo;

  logic         model_ack = 1'b0;
  logic         force_ack = 1'b0;
  logic [W-1:0] model_y = '0;

  int n_cmp = 0;
  int n_bad = 0;
  int run_pulses = 0;
  int stab_viol = 0;
  int early_issue = 0;
  int run_base = 0;

  vec_t vecs[$];
  vec_t sb[$];

  alu_mdu_ctrl_if #(.OPR_L(W)) alu_bus ();

  assign alu_bus.alu_ack = model_ack | force_ack;
  assign alu_bus.alu_Y   = model_y;

  alu_mdu_ctrl #(.OPR_L(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op_div (op_div),
    .opa    (opa),
    .opb    (opb),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .hi     (hi),
    .lo     (lo),
    .alu    (alu_bus.master)
  );

  always #5 clk = ~clk;

  // ALU model: acks after 1-5 cycles, releases 1-5 cycles after run drops.
  int ack_dly;
  always begin
    @(negedge clk);
    if (alu_bus.alu_run && !model_ack) begin
      ack_dly = $urandom_range(1, 5);
      repeat (ack_dly - 1) @(negedge clk);
      if (alu_bus.alu_run) begin
        case (alu_bus.alu_op)
          OP_ADD:  model_y = alu_bus.alu_A + alu_bus.alu_B;
          OP_SUB:  model_y = alu_bus.alu_A - alu_bus.alu_B;
          OP_SLTU: model_y = {{(W-1){1'b0}}, (alu_bus.alu_A < alu_bus.alu_B)};
          default: model_y = '0;
        endcase
        model_ack = 1'b1;
        while (alu_bus.alu_run) @(negedge clk);
        ack_dly = $urandom_range(1, 5);
        repeat (ack_dly - 1) @(negedge clk);
        model_ack = 1'b0;
      end
    end
  end

  // Handshake monitor around every rising edge.
  logic         pre_run, pre_ack, pre_rst;
  logic [W-1:0] pre_a, pre_b;
  logic [`ALUOP_L-1:0] pre_op;
  always begin
    @(posedge clk);
    pre_run = alu_bus.alu_run;
    pre_ack = alu_bus.alu_ack;
    pre_rst = rst;
    pre_a   = alu_bus.alu_A;
    pre_b   = alu_bus.alu_B;
    pre_op  = alu_bus.alu_op;
    #1;
    if (!pre_run && alu_bus.alu_run && !rst) run_pulses++;
    if (!pre_run && alu_bus.alu_run && pre_ack) early_issue++;
    if ((pre_run || pre_ack) && !pre_rst && !rst &&
        (alu_bus.alu_A !== pre_a || alu_bus.alu_B !== pre_b || alu_bus.alu_op !== pre_op))
      stab_viol++;
  end

  initial begin
    #800000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic reportFail(input string name);
    n_cmp++;
    n_bad++;
    $display("[TB] FAIL %s: bound expired, got no response, expected one", name);
  endtask

  function automatic vec_t mkVec(input int id, input logic d, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] eh, input logic [W-1:0] el, input logic ee,
                                 input int runs, input int lat);
    vec_t v;
    v.id = id; v.op_div = d; v.a = a; v.b = b;
    v.exp_hi = eh; v.exp_lo = el; v.exp_err = ee;
    v.exp_runs = runs; v.exp_lat = lat;
    return v;
  endfunction

  function automatic vec_t mkMul(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    return mkVec(id, 1'b0, a, b, p[63:32], p[31:0], 1'b0, 2 * $countones(a), 0);
  endfunction

  task automatic applyStimulus(input vec_t v);
    int guard = 0;
    @(negedge clk);
    while (busy && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (busy) reportFail($sformatf("idle_wait[%0d]", v.id));
    start    = 1'b1;
    op_div   = v.op_div;
    opa      = v.a;
    opb      = v.b;
    run_base = run_pulses;
    sb.push_back(v);
    @(negedge clk);
    start = 1'b0;
    opa   = $urandom;
    opb   = $urandom;
    checkVal($sformatf("busy_after_start[%0d]", v.id), busy, 1);
  endtask

  task automatic checkOutput(input bit restart_at_done);
    vec_t e;
    int lat = 1;
    while (!done && lat < 5000) begin
      @(negedge clk);
      lat++;
    end
    if (!done) begin
      reportFail("done_wait");
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    if (sb.size() == 0) begin
      reportFail("scoreboard_empty");
      return;
    end
    e = sb.pop_front();
    checkVal($sformatf("hi[%0d]", e.id), hi, e.exp_hi);
    checkVal($sformatf("lo[%0d]", e.id), lo, e.exp_lo);
    checkVal($sformatf("err[%0d]", e.id), err, e.exp_err);
    if (e.exp_runs >= 0) checkVal($sformatf("alu_runs[%0d]", e.id), run_pulses - run_base, e.exp_runs);
    if (e.exp_lat > 0) checkVal($sformatf("done_latency[%0d]", e.id), lat, e.exp_lat);
    if (restart_at_done) begin
      start  = 1'b1;
      op_div = 1'b0;
      opa    = 2;
      opb    = 2;
    end
    @(negedge clk);
    start = 1'b0;
    checkVal($sformatf("done_pulse[%0d]", e.id), done, 0);
    checkVal($sformatf("busy_after_done[%0d]", e.id), busy, 0);
  endtask

  initial begin
    vec_t v;
    int guard;
    rst = 1'b1; start = 1'b0; op_div = 1'b0; opa = '0; opb = '0;

    vecs.push_back(mkVec(1, 1'b0, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 4, 0));
    vecs.push_back(mkVec(2, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 64, 0));
    vecs.push_back(mkVec(3, 1'b0, 32'd0, 32'h1234, 32'd0, 32'd0, 1'b0, 0, 0));
    vecs.push_back(mkVec(4, 1'b0, 32'h80000000, 32'd2, 32'd1, 32'd0, 1'b0, 2, 0));
    vecs.push_back(mkVec(5, 1'b0, 32'h00010000, 32'h00010000, 32'd1, 32'd0, 1'b0, 2, 0));
    vecs.push_back(mkMul(6, 32'hDEADBEEF, 32'h12345678));
    vecs.push_back(mkMul(7, 32'hA5A5A5A5, 32'h5A5A5A5A));
`ifdef ALU_MDU_DIV_EN
    vecs.push_back(mkVec(10, 1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, -1, 0));
    vecs.push_back(mkVec(11, 1'b1, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b1, 0, 1));
    vecs.push_back(mkVec(12, 1'b1, 32'hFFFFFFFF, 32'd1, 32'd0, 32'hFFFFFFFF, 1'b0, -1, 0));
    vecs.push_back(mkVec(13, 1'b1, 32'd7, 32'd100, 32'd7, 32'd0, 1'b0, -1, 0));
    vecs.push_back(mkVec(14, 1'b1, 32'h80000000, 32'd3, 32'd2, 32'h2AAAAAAA, 1'b0, -1, 0));
    vecs.push_back(mkVec(15, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd1, 1'b0, -1, 0));
    vecs.push_back(mkVec(16, 1'b1, 32'hDEADBEEF, 32'h1234, 32'hDEADBEEF % 32'h1234,
                         32'hDEADBEEF / 32'h1234, 1'b0, -1, 0));
`else
    vecs.push_back(mkVec(20, 1'b1, 32'd9, 32'd3, 32'd0, 32'd0, 1'b1, 0, 1));
    vecs.push_back(mkVec(21, 1'b1, 32'd5, 32'd0, 32'd0, 32'd0, 1'b1, 0, 1));
`endif

    repeat (3) @(negedge clk);
    checkVal("reset_busy", busy, 0);
    checkVal("reset_done", done, 0);
    checkVal("reset_err", err, 0);
    checkVal("reset_alu_run", alu_bus.alu_run, 0);
    checkVal("reset_alu_A", alu_bus.alu_A, 0);
    checkVal("reset_alu_B", alu_bus.alu_B, 0);
    checkVal("reset_alu_op", alu_bus.alu_op, 0);
    checkVal("reset_alu_c", alu_bus.alu_c, 0);
    checkVal("reset_hi", hi, 0);
    checkVal("reset_lo", lo, 0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput(1'b0);
    end

    // start pulses while busy must not disturb the running multiply, and results must hold afterwards
    applyStimulus(mkVec(30, 1'b0, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0, 6, 0));
    repeat (2) @(negedge clk);
    start = 1'b1; op_div = 1'b1; opa = 32'hFFFFFFFF; opb = 32'd0;
    repeat (2) @(negedge clk);
    start = 1'b0;
    checkOutput(1'b0);
    repeat (5) @(negedge clk);
    checkVal("hold_hi[30]", hi, 32'd0);
    checkVal("hold_lo[30]", lo, 32'd42);

    // start presented in the done cycle is ignored
    applyStimulus(mkVec(31, 1'b0, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 4, 0));
    checkOutput(1'b1);
    @(negedge clk);
    checkVal("ignored_start_busy[31]", busy, 0);
    checkVal("ignored_start_lo[31]", lo, 32'd15);

    // reset while waiting for ack, with a stale ack held afterwards
    @(negedge clk);
    start = 1'b1; op_div = 1'b0; opa = 32'hF; opb = 32'd3;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (!alu_bus.alu_run && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!alu_bus.alu_run) reportFail("wait_ack_entry");
    force_ack = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    checkVal("midrst_busy", busy, 0);
    checkVal("midrst_done", done, 0);
    checkVal("midrst_err", err, 0);
    checkVal("midrst_alu_run", alu_bus.alu_run, 0);
    checkVal("midrst_alu_A", alu_bus.alu_A, 0);
    checkVal("midrst_alu_B", alu_bus.alu_B, 0);
    checkVal("midrst_alu_op", alu_bus.alu_op, 0);
    checkVal("midrst_hi", hi, 0);
    checkVal("midrst_lo", lo, 0);
    rst = 1'b0;
    applyStimulus(mkVec(32, 1'b0, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 4, 0));
    @(negedge clk);
    checkVal("run_held_by_stale_ack", alu_bus.alu_run, 0);
    force_ack = 1'b0;
    checkOutput(1'b0);

    checkVal("operand_stability_violations", stab_viol, 0);
    checkVal("issue_while_ack_high", early_issue, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
